// File: rtl/readout_feature_packer.sv
// Quantizes a stream of signed readout samples into QBITS-wide codes and packs one shot per vector.
// Optional build macro PACKER_STATS_EN adds shots_out / sat_count counters.
module readout_feature_packer #(
  parameter int IN_W     = 16,
  parameter int QBITS    = 2,
  parameter int NUM_FEAT = 32,
  parameter int SHIFT    = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [IN_W-1:0]    s_data,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic [NUM_FEAT*QBITS-1:0] m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      frame_err
`ifdef PACKER_STATS_EN
  ,
  output logic [31:0]               shots_out,
  output logic [31:0]               sat_count
`endif
);

  localparam int VW = NUM_FEAT * QBITS;
  localparam int CW = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic signed [IN_W:0] MID_W = (IN_W+1)'(2 ** (QBITS - 1));
  localparam logic signed [IN_W:0] MAX_W = (IN_W+1)'(2 ** QBITS - 1);
  localparam logic [QBITS-1:0]     MID_CODE = QBITS'(2 ** (QBITS - 1));
  localparam logic [VW-1:0]        MID_VEC = {NUM_FEAT{MID_CODE}};

  // Valid/ready: a beat or vector moves only in a cycle where valid and ready are both high;
  // a producer holds data stable while valid is high and ready is low.
  typedef enum logic [1:0] {COLLECT = 2'd0, DRAIN = 2'd1, FULL = 2'd2} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [VW-1:0]   asm_reg;
  logic [VW-1:0]   asm_next;
  logic            pend;

  logic signed [IN_W-1:0] shifted;
  logic signed [IN_W:0]   q_wide;
  logic [QBITS-1:0]       code;
  logic                   clamped;

  logic accept;
  logic in_collect;
  logic at_end;
  logic close;
  logic out_free;
  logic direct_xfer;
  logic pend_xfer;
  logic malformed;

  always_comb begin
    shifted = s_data >>> SHIFT;
    q_wide  = {shifted[IN_W-1], shifted} + MID_W;
    clamped = 1'b0;
    code    = q_wide[QBITS-1:0];
    if (q_wide[IN_W]) begin
      code    = '0;
      clamped = 1'b1;
    end else if (q_wide > MAX_W) begin
      code    = '1;
      clamped = 1'b1;
    end
  end

  always_comb begin
    asm_next = asm_reg;
    for (int k = 0; k < NUM_FEAT; k++) begin
      if (cnt == CW'(k)) asm_next[k*QBITS +: QBITS] = code;
    end
  end

  always_comb begin
    accept      = s_valid & s_ready;
    in_collect  = (state == COLLECT);
    at_end      = (cnt == CW'(NUM_FEAT - 1));
    close       = in_collect & accept & (s_last | at_end);
    out_free    = ~m_valid | m_ready;
    // A closing beat bypasses the assembly register so a free output sees it next cycle.
    direct_xfer = close & out_free;
    pend_xfer   = pend & out_free;
    malformed   = close & ~(s_last & at_end);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: begin
        if (close) begin
          if (!s_last)       state_nxt = DRAIN;
          else if (out_free) state_nxt = COLLECT;
          else               state_nxt = FULL;
        end
      end
      DRAIN: begin
        if (accept && s_last) state_nxt = (pend && !out_free) ? FULL : COLLECT;
      end
      FULL: begin
        if (out_free) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    s_ready = (state != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      frame_err <= 1'b0;
      cnt       <= '0;
      asm_reg   <= MID_VEC;
      pend      <= 1'b0;
    end else begin
      frame_err <= malformed;
      if (direct_xfer || pend_xfer) begin
        m_valid <= 1'b1;
        m_data  <= direct_xfer ? asm_next : asm_reg;
        asm_reg <= MID_VEC;
        pend    <= 1'b0;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (close) begin
        cnt <= '0;
        if (!out_free) begin
          asm_reg <= asm_next;
          pend    <= 1'b1;
        end
      end else if (in_collect && accept) begin
        asm_reg <= asm_next;
        cnt     <= cnt + CW'(1);
      end
    end
  end

`ifdef PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      shots_out <= '0;
      sat_count <= '0;
    end else begin
      if (m_valid && m_ready)               shots_out <= shots_out + 32'd1;
      if (in_collect && accept && clamped)  sat_count <= sat_count + 32'd1;
    end
  end
`endif

endmodule
